eth_phy_10g_hdr_err_inject: RTL and testbench

SerDes-side sync-header error injector for the 10G PHY bench and link-test paths. It sits between `serdes_tx_data`/`serdes_tx_hdr` of one PHY and `serdes_rx_data`/`serdes_rx_hdr` of the receiving PHY. Under a pseudo-random, threshold-controlled schedule it replaces the 64b/66b sync header with an invalid code, optionally in bursts, and counts injected and total blocks. The receiver's BER monitor, block-lock and watchdog logic can then be exercised deterministically in RTL.

---
 rtl/eth_phy_10g_inject_pkg.sv | 24 ++
 rtl/eth_phy_10g_inject_lfsr.sv | 41 ++++
 rtl/eth_phy_10g_hdr_err_inject.sv | 188 ++++++++++++++++++
 tb/tb_eth_phy_10g_hdr_err_inject.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_phy_10g_inject_pkg.sv
// Shared types and constants for the 10G sync-header error injector.
package eth_phy_10g_inject_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_BURST = 2'd2,
      ST_DONE  = 2'd3
   } inj_state_e;

   localparam logic [1:0]  SYNC_DATA = 2'b01;
   localparam logic [1:0]  SYNC_CTRL = 2'b10;
   localparam logic [1:0]  HDR_BAD_A = 2'b11;
   localparam logic [1:0]  HDR_BAD_B = 2'b00;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      logic [15:0] shifted;
      shifted = {1'b0, cur[15:1]};
      return cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
   endfunction

endpackage

// File: rtl/eth_phy_10g_inject_lfsr.sv
// Seedable, step-enabled 16-bit Galois LFSR; exposes the low byte used for
// the injection decision.
module eth_phy_10g_inject_lfsr
   import eth_phy_10g_inject_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       step,
   output logic [7:0] rnd
);

   logic [15:0] lfsr_d;
   logic [15:0] lfsr_q;

   // Next-state selection: reload wins over stepping.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = SEED;
      end else if (step) begin
         lfsr_d = lfsr_next(lfsr_q);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // LFSR state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign rnd = lfsr_q[7:0];

endmodule

// File: rtl/eth_phy_10g_hdr_err_inject.sv
// SerDes-side 64b/66b sync-header error injector with burst and run control.
// Optional payload corruption is enabled by defining HDR_INJECT_DATA_CORRUPT_EN.
module eth_phy_10g_hdr_err_inject
   import eth_phy_10g_inject_pkg::*;
#(
   parameter int          DATA_WIDTH  = 64,
   parameter int          HDR_WIDTH   = 2,
   parameter int          COUNT_WIDTH = 32,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic [HDR_WIDTH-1:0]   in_hdr,
   input  logic                   in_valid,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [HDR_WIDTH-1:0]   out_hdr,
   output logic                   out_valid,
   input  logic                   cfg_enable,
   input  logic [7:0]             cfg_threshold,
   input  logic [7:0]             cfg_burst_len,
   input  logic [COUNT_WIDTH-1:0] cfg_block_count,
`ifdef HDR_INJECT_DATA_CORRUPT_EN
   input  logic [DATA_WIDTH-1:0]  cfg_data_mask,
`endif
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   hdr_inject,
   output logic [COUNT_WIDTH-1:0] inject_count,
   output logic [COUNT_WIDTH-1:0] total_count
);

   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : (v + CNT_ONE);
   endfunction

   inj_state_e              state_d, state_q;
   logic [7:0]              burst_rem_d, burst_rem_q;
   logic                    toggle_d, toggle_q;
   logic [COUNT_WIDTH-1:0]  inject_count_d, inject_count_q;
   logic [COUNT_WIDTH-1:0]  total_count_d, total_count_q;
   logic [DATA_WIDTH-1:0]   out_data_d, out_data_q;
   logic [HDR_WIDTH-1:0]    out_hdr_d, out_hdr_q;
   logic                    out_valid_d, out_valid_q;
   logic                    hdr_inject_d, hdr_inject_q;
   logic                    busy_d, busy_q;
   logic                    done_d, done_q;
   logic                    lfsr_load_s;
   logic                    lfsr_step_s;
   logic                    inject_s;
   logic [7:0]              lfsr_rnd_s;
   logic [7:0]              burst_len_eff_s;

   eth_phy_10g_inject_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load_s),
      .step (lfsr_step_s),
      .rnd  (lfsr_rnd_s)
   );

   assign burst_len_eff_s = (cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len;

   // FSM next state, header/payload corruption and run statistics.
   always_comb begin
      state_d        = state_q;
      burst_rem_d    = burst_rem_q;
      toggle_d       = toggle_q;
      inject_count_d = inject_count_q;
      total_count_d  = total_count_q;
      out_data_d     = in_data;
      out_hdr_d      = in_hdr;
      out_valid_d    = in_valid;
      hdr_inject_d   = 1'b0;
      lfsr_load_s    = 1'b0;
      lfsr_step_s    = 1'b0;
      inject_s       = 1'b0;

      if (!cfg_enable) begin
         state_d = ST_IDLE;
      end else if (start) begin
         // A start from any enabled state (re)begins a fresh run.
         state_d        = ST_RUN;
         inject_count_d = CNT_ZERO;
         total_count_d  = CNT_ZERO;
         burst_rem_d    = 8'd0;
         toggle_d       = 1'b0;
         lfsr_load_s    = 1'b1;
      end else begin
         case (state_q)
            ST_RUN, ST_BURST: begin
               if (in_valid) begin
                  lfsr_step_s   = 1'b1;
                  total_count_d = sat_inc(total_count_q);
                  inject_s      = (state_q == ST_BURST) || (lfsr_rnd_s < cfg_threshold);

                  if (inject_s) begin
                     out_hdr_d      = toggle_q ? HDR_BAD_B : HDR_BAD_A;
                     toggle_d       = ~toggle_q;
                     inject_count_d = sat_inc(inject_count_q);
                     hdr_inject_d   = 1'b1;
`ifdef HDR_INJECT_DATA_CORRUPT_EN
                     out_data_d     = in_data ^ cfg_data_mask;
`else
                     out_data_d     = in_data;
`endif
                  end else begin
                     out_hdr_d = in_hdr;
                  end

                  if (state_q == ST_BURST) begin
                     burst_rem_d = burst_rem_q - 8'd1;
                     state_d     = (burst_rem_q <= 8'd1) ? ST_RUN : ST_BURST;
                  end else if (inject_s && (burst_len_eff_s > 8'd1)) begin
                     burst_rem_d = burst_len_eff_s - 8'd1;
                     state_d     = ST_BURST;
                  end else begin
                     state_d = ST_RUN;
                  end

                  // Run-length termination overrides any pending burst.
                  if ((cfg_block_count != CNT_ZERO) && (total_count_d == cfg_block_count)) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = state_d;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_IDLE, ST_DONE: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d == ST_RUN) || (state_d == ST_BURST);
      done_d = (state_d == ST_DONE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         burst_rem_q    <= 8'd0;
         toggle_q       <= 1'b0;
         inject_count_q <= CNT_ZERO;
         total_count_q  <= CNT_ZERO;
         out_data_q     <= {DATA_WIDTH{1'b0}};
         out_hdr_q      <= {HDR_WIDTH{1'b0}};
         out_valid_q    <= 1'b0;
         hdr_inject_q   <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         burst_rem_q    <= burst_rem_d;
         toggle_q       <= toggle_d;
         inject_count_q <= inject_count_d;
         total_count_q  <= total_count_d;
         out_data_q     <= out_data_d;
         out_hdr_q      <= out_hdr_d;
         out_valid_q    <= out_valid_d;
         hdr_inject_q   <= hdr_inject_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign out_data     = out_data_q;
   assign out_hdr      = out_hdr_q;
   assign out_valid    = out_valid_q;
   assign hdr_inject   = hdr_inject_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign inject_count = inject_count_q;
   assign total_count  = total_count_q;

endmodule

// File: tb/tb_eth_phy_10g_hdr_err_inject.sv
// Scoreboard bench for the sync-header error injector (default build).
module tb_eth_phy_10g_hdr_err_inject;
   import eth_phy_10g_inject_pkg::*;

   localparam int DW = 64;
   localparam int CW = 32;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    hdr;
      logic          inj;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_data;
   logic [1:0]    in_hdr;
   logic          in_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    out_hdr;
   logic          out_valid;
   logic          cfg_enable;
   logic [7:0]    cfg_threshold;
   logic [7:0]    cfg_burst_len;
   logic [CW-1:0] cfg_block_count;
   logic          start;
   logic          busy;
   logic          done;
   logic          hdr_inject;
   logic [CW-1:0] inject_count;
   logic [CW-1:0] total_count;

   exp_t exp_q[$];
   int   total_cnt  = 0;
   int   bad_cnt    = 0;
   int   mon_total  = 0;
   int   mon_bad    = 0;
   logic prev_valid = 1'b0;

   // Pattern for burst/reset tests: threshold 0x80, burst 2, seed 0xACE1.
   logic       pat_inj [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [1:0] pat_hdr [6] = '{SYNC_DATA, HDR_BAD_A, HDR_BAD_B, SYNC_DATA, HDR_BAD_A, HDR_BAD_B};

   always #5 clk = ~clk;

   eth_phy_10g_hdr_err_inject dut (
      .clk             (clk),
      .rst             (rst),
      .in_data         (in_data),
      .in_hdr          (in_hdr),
      .in_valid        (in_valid),
      .out_data        (out_data),
      .out_hdr         (out_hdr),
      .out_valid       (out_valid),
      .cfg_enable      (cfg_enable),
      .cfg_threshold   (cfg_threshold),
      .cfg_burst_len   (cfg_burst_len),
      .cfg_block_count (cfg_block_count),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .hdr_inject      (hdr_inject),
      .inject_count    (inject_count),
      .total_count     (total_count)
   );

   function automatic logic [DW-1:0] pat(input int i);
      return {32'hA5A5_0000 ^ 32'(i), (32'(i) * 32'd3) + 32'h1234_0000};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] h, input logic [DW-1:0] d, input logic st);
      @(negedge clk);
      check("out_valid_delay", 64'(out_valid), 64'(prev_valid));
      in_valid   = v;
      in_hdr     = h;
      in_data    = d;
      start      = st;
      prev_valid = v;
   endtask

   task automatic send(input logic [1:0] h, input logic [DW-1:0] d, input logic e_inj, input logic [1:0] e_hdr);
      exp_t e;
      drive(1'b1, h, d, 1'b0);
      e.data = d;
      e.hdr  = e_hdr;
      e.inj  = e_inj;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      drive(1'b0, SYNC_CTRL, {DW{1'b0}}, 1'b0);
   endtask

   task automatic do_start();
      drive(1'b0, SYNC_CTRL, {DW{1'b0}}, 1'b1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_out_data"}, 64'(out_data), 64'd0);
      check({tag, "_out_hdr"}, 64'(out_hdr), 64'd0);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_hdr_inject"}, 64'(hdr_inject), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_inject_count"}, 64'(inject_count), 64'd0);
      check({tag, "_total_count"}, 64'(total_count), 64'd0);
   endtask

   task automatic check_run(input string tag, input int inj, input int tot, input logic b, input logic dn);
      check({tag, "_inject_count"}, 64'(inject_count), 64'(inj));
      check({tag, "_total_count"}, 64'(total_count), 64'(tot));
      check({tag, "_busy"}, 64'(busy), 64'(b));
      check({tag, "_done"}, 64'(done), 64'(dn));
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a valid block.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         mon_total++;
         if (exp_q.size() == 0) begin
            mon_bad++;
            $display("FAIL block_unexpected: got hdr=%b data=%h with empty scoreboard", out_hdr, out_data);
         end else begin
            e = exp_q.pop_front();
            if (out_hdr !== e.hdr || out_data !== e.data || hdr_inject !== e.inj) begin
               mon_bad++;
               $display("FAIL block: got hdr=%b inj=%b data=%h expected hdr=%b inj=%b data=%h",
                        out_hdr, hdr_inject, out_data, e.hdr, e.inj, e.data);
            end
         end
      end else begin
         mon_total++;
         if (hdr_inject !== 1'b0) begin
            mon_bad++;
            $display("FAIL inject_without_valid: got hdr_inject=%b expected 0", hdr_inject);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      in_valid        = 1'b0;
      in_hdr          = SYNC_CTRL;
      in_data         = {DW{1'b0}};
      start           = 1'b0;
      cfg_enable      = 1'b0;
      cfg_threshold   = 8'd0;
      cfg_burst_len   = 8'd1;
      cfg_block_count = 32'd0;
      #1;
      check_reset_vals("reset");
      repeat (2) @(negedge clk);
      rst        = 1'b0;
      cfg_enable = 1'b1;

      // No injection over a 1000-block run.
      cfg_threshold   = 8'd0;
      cfg_burst_len   = 8'd1;
      cfg_block_count = 32'd1000;
      do_start();
      for (int i = 0; i < 1000; i++) begin
         send(i[0] ? SYNC_CTRL : SYNC_DATA, pat(i), 1'b0, i[0] ? SYNC_CTRL : SYNC_DATA);
      end
      idle();
      check_run("noinj", 0, 1000, 1'b0, 1'b1);

      // Always inject: low LFSR bytes E1,70,38,9C,4E,27,13,89,C4,62 all < 255.
      cfg_threshold   = 8'd255;
      cfg_burst_len   = 8'd1;
      cfg_block_count = 32'd10;
      do_start();
      for (int i = 0; i < 10; i++) begin
         send(SYNC_DATA, pat(i + 2000), 1'b1, i[0] ? HDR_BAD_B : HDR_BAD_A);
      end
      idle();
      check_run("always", 10, 10, 1'b0, 1'b1);

      // Burst of 4 triggered by seed byte 0xE1 < 0xE2, then threshold 0 in RUN.
      cfg_threshold   = 8'hE2;
      cfg_burst_len   = 8'd4;
      cfg_block_count = 32'd0;
      do_start();
      send(SYNC_DATA, pat(3000), 1'b1, HDR_BAD_A);
      @(posedge clk);
      #1;
      cfg_threshold = 8'd0;
      send(SYNC_DATA, pat(3001), 1'b1, HDR_BAD_B);
      send(SYNC_CTRL, pat(3002), 1'b1, HDR_BAD_A);
      send(SYNC_DATA, pat(3003), 1'b1, HDR_BAD_B);
      send(SYNC_CTRL, pat(3004), 1'b0, SYNC_CTRL);
      send(SYNC_DATA, pat(3005), 1'b0, SYNC_DATA);
      idle();
      check_run("burst", 4, 6, 1'b1, 1'b0);
      cfg_enable = 1'b0;
      idle();
      idle();
      check_run("disable", 4, 6, 1'b0, 1'b0);
      cfg_enable = 1'b1;

      // Termination in the middle of a burst.
      cfg_threshold   = 8'd255;
      cfg_burst_len   = 8'd8;
      cfg_block_count = 32'd2;
      do_start();
      send(SYNC_DATA, pat(4000), 1'b1, HDR_BAD_A);
      send(SYNC_DATA, pat(4001), 1'b1, HDR_BAD_B);
      send(SYNC_CTRL, pat(4002), 1'b0, SYNC_CTRL);
      idle();
      check_run("term", 2, 2, 1'b0, 1'b1);

      // Gaps in in_valid: only valid blocks are counted.
      cfg_threshold   = 8'd0;
      cfg_burst_len   = 8'd1;
      cfg_block_count = 32'd0;
      do_start();
      send(SYNC_DATA, pat(5000), 1'b0, SYNC_DATA);
      idle();
      send(SYNC_CTRL, pat(5001), 1'b0, SYNC_CTRL);
      idle();
      idle();
      send(SYNC_DATA, pat(5002), 1'b0, SYNC_DATA);
      idle();
      check_run("gaps", 0, 3, 1'b1, 1'b0);
      cfg_enable = 1'b0;
      idle();
      idle();
      cfg_enable = 1'b1;

      // Reset mid-burst, then restart reproduces the same pattern.
      cfg_threshold   = 8'h80;
      cfg_burst_len   = 8'd2;
      cfg_block_count = 32'd0;
      do_start();
      for (int i = 0; i < 5; i++) begin
         send(SYNC_DATA, pat(6000 + i), pat_inj[i], pat_hdr[i]);
      end
      idle();
      check_run("prereset", 3, 5, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("midreset");
      @(negedge clk);
      rst        = 1'b0;
      prev_valid = 1'b0;
      do_start();
      for (int i = 0; i < 6; i++) begin
         send(SYNC_DATA, pat(7000 + i), pat_inj[i], pat_hdr[i]);
      end
      idle();
      check_run("restart", 4, 6, 1'b1, 1'b0);

      repeat (3) idle();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      total_cnt += mon_total;
      bad_cnt   += mon_bad;
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
